// File: rtl/arm_pkg.sv
// Shared types and width defaults for the ARM pipeline memory-side blocks.
package arm_pkg;

  localparam int unsigned ARM_ADDR_W = 32;
  localparam int unsigned ARM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2
  } arb_state_e;

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared I/D SRAM between the IF and MEM stages, bounds every
// access with a wait timeout and generates the pipeline freeze signals.
module mem_port_arbiter
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_W        = ARM_ADDR_W,
  parameter int unsigned DATA_W        = ARM_DATA_W,
  parameter int unsigned WAIT_MAX      = 15,
  parameter int unsigned MEM_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,

  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,

  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,

  output logic              timeout,
  output logic              freeze_if,
  output logic              freeze_pipe
);

  localparam int unsigned WCNT_W = cnt_width(WAIT_MAX);
  localparam int unsigned BCNT_W = cnt_width(MEM_BURST_MAX);

  // wait_cnt holds the number of grant cycles already elapsed, so the abort
  // fires at the end of the WAIT_MAX-th unacknowledged grant cycle.
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);
  localparam logic [BCNT_W-1:0] BURST_CAP = BCNT_W'(MEM_BURST_MAX);

  arb_state_e          state_q,      state_d;
  logic                sram_req_q,   sram_req_d;
  logic                sram_we_q,    sram_we_d;
  logic [ADDR_W-1:0]   sram_addr_q,  sram_addr_d;
  logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q,  mem_rdata_d;
  logic                if_ack_q,     if_ack_d;
  logic                mem_ack_q,    mem_ack_d;
  logic                timeout_q,    timeout_d;
  logic [WCNT_W-1:0]   wait_cnt_q,   wait_cnt_d;
  logic [BCNT_W-1:0]   burst_cnt_q,  burst_cnt_d;

  logic if_elig;
  logic mem_elig;
  logic if_turn;
  logic grant_mem;
  logic grant_if;
  logic xfer_done;
  logic xfer_abort;

  // A requester whose ack is on the wire this cycle is still holding req
  // for the access just completed; it must not be granted a second time.
  assign if_elig    = if_req  & ~if_ack_q;
  assign mem_elig   = mem_req & ~mem_ack_q;
  assign if_turn    = if_elig & (burst_cnt_q == BURST_CAP);
  assign grant_mem  = mem_elig & ~if_turn;
  assign grant_if   = if_elig & ~grant_mem;

  assign xfer_done  = sram_req_q & sram_ack;
  assign xfer_abort = sram_req_q & ~sram_ack & (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    timeout_d    = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    burst_cnt_d  = burst_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (!if_req) begin
          burst_cnt_d = '0;
        end
        if (grant_mem) begin
          state_d      = GRANT_MEM;
          sram_req_d   = 1'b1;
          sram_we_d    = mem_we;
          sram_addr_d  = mem_addr;
          sram_wdata_d = mem_wdata;
          wait_cnt_d   = '0;
          if (if_req && (burst_cnt_q != BURST_CAP)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d     = GRANT_IF;
          sram_req_d  = 1'b1;
          sram_we_d   = 1'b0;
          sram_addr_d = if_addr;
          wait_cnt_d  = '0;
          burst_cnt_d = '0;
        end
      end

      GRANT_IF, GRANT_MEM: begin
        if (xfer_done || xfer_abort) begin
          state_d    = IDLE;
          sram_req_d = 1'b0;
          timeout_d  = xfer_abort;
          if (state_q == GRANT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = xfer_done ? sram_rdata : '0;
          end else begin
            mem_ack_d = 1'b1;
            if (xfer_abort) begin
              mem_rdata_d = '0;
            end else if (!sram_we_q) begin
              mem_rdata_d = sram_rdata;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        sram_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      timeout_q    <= 1'b0;
      wait_cnt_q   <= '0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      timeout_q    <= timeout_d;
      wait_cnt_q   <= wait_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign sram_req    = sram_req_q;
  assign sram_we     = sram_we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wdata  = sram_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign if_ack      = if_ack_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_ack     = mem_ack_q;
  assign timeout     = timeout_q;

  assign freeze_if   = if_req  & ~if_ack_q;
  assign freeze_pipe = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences and a randomized two-requester run against a memory model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned WMAX = 15;
  localparam int unsigned BMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          sram_ack;
  logic          timeout;
  logic          freeze_if;
  logic          freeze_pipe;

  int errors = 0;
  int checks = 0;

  int sram_waits = 0;
  bit never_ack  = 1'b0;
  bit rand_waits = 1'b0;
  int resp_cyc   = 0;
  int resp_w     = 0;

  logic [31:0] smem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          mem_ack_count = 0;
  logic [31:0] exp_mem_rdata = '0;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          hang;
    logic [31:0] exp_rdata;
    bit          exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .WAIT_MAX     (WMAX),
    .MEM_BURST_MAX(BMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ack   (sram_ack),
    .timeout    (timeout),
    .freeze_if  (freeze_if),
    .freeze_pipe(freeze_pipe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fill_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  // SRAM responder: acks after a programmable number of extra cycles.
  initial begin
    sram_ack   = 1'b0;
    sram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      sram_ack = 1'b0;
      if (sram_req !== 1'b1) begin
        resp_cyc = 0;
      end else begin
        if (resp_cyc == 0) resp_w = rand_waits ? int'($urandom_range(0, 3)) : sram_waits;
        if (!never_ack && resp_cyc == resp_w) begin
          sram_ack = 1'b1;
          if (sram_we) smem[sram_addr] = sram_wdata;
          else sram_rdata = smem.exists(sram_addr) ? smem[sram_addr] : fill_word(sram_addr);
        end
        resp_cyc++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_vec(input int idx, input vec_t v);
    int lat = 0;
    bit got = 1'b0;
    bit seen_req = 1'b0;
    bit we_ok = 1'b1;
    bit wd_ok = 1'b1;
    bit frz_ok = 1'b1;
    logic [31:0] rd;
    logic to;
    logic frz;
    sram_waits = v.waits;
    never_ack  = v.hang;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (sram_req === 1'b1) begin
        seen_req = 1'b1;
        if (sram_we !== v.we) we_ok = 1'b0;
        if (v.we && sram_wdata !== v.wdata) wd_ok = 1'b0;
      end
      got = v.is_mem ? mem_ack : if_ack;
      frz = v.is_mem ? freeze_pipe : freeze_if;
      if (frz !== !got) frz_ok = 1'b0;
    end
    rd = v.is_mem ? mem_rdata : if_rdata;
    to = timeout;
    mem_req = 1'b0;
    if_req  = 1'b0;
    check($sformatf("v%0d_ack_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    check($sformatf("v%0d_timeout", idx), 32'(to), 32'(v.exp_to));
    check($sformatf("v%0d_sram_req_seen", idx), 32'(seen_req), 32'd1);
    check($sformatf("v%0d_sram_we", idx), 32'(we_ok), 32'd1);
    check($sformatf("v%0d_sram_wdata_held", idx), 32'(wd_ok), 32'd1);
    check($sformatf("v%0d_freeze", idx), 32'(frz_ok), 32'd1);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_ack_one_cycle", idx), 32'(v.is_mem ? mem_ack : if_ack), 32'd0);
    check($sformatf("v%0d_timeout_one_cycle", idx), 32'(timeout), 32'd0);
  endtask

  task automatic if_driver(input int n);
    for (int t = 0; t < n; t++) begin
      int gap;
      int k;
      int mstart;
      logic [31:0] a;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        if_req = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      a = 32'h300 + 32'(4 * $urandom_range(0, 7));
      if_addr = a;
      if_req  = 1'b1;
      mstart  = mem_ack_count;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (if_ack !== 1'b1 && k < 200);
      check("rnd_if_ack_seen", 32'(if_ack), 32'd1);
      check("rnd_if_rdata", if_rdata, ref_mem[a]);
      check("rnd_if_timeout", 32'(timeout), 32'd0);
      check("rnd_if_mem_grants_bounded", 32'((mem_ack_count - mstart) <= int'(BMAX) + 1), 32'd1);
    end
    if_req = 1'b0;
  endtask

  task automatic mem_driver(input int n);
    for (int t = 0; t < n; t++) begin
      int gap;
      int k;
      logic [31:0] a;
      logic [31:0] wd;
      bit we;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        mem_req = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      a  = 32'h300 + 32'(4 * $urandom_range(0, 7));
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      mem_addr = a; mem_wdata = wd; mem_we = we; mem_req = 1'b1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (mem_ack !== 1'b1 && k < 200);
      check("rnd_mem_ack_seen", 32'(mem_ack), 32'd1);
      if (we) begin
        check("rnd_mem_store_keeps_rdata", mem_rdata, exp_mem_rdata);
        ref_mem[a] = wd;
      end else begin
        check("rnd_mem_load_rdata", mem_rdata, ref_mem[a]);
        exp_mem_rdata = ref_mem[a];
      end
      check("rnd_mem_timeout", 32'(timeout), 32'd0);
      mem_ack_count++;
    end
    mem_req = 1'b0;
  endtask

  initial begin
    int k;
    int mlat;
    int ilat;
    int nacks;
    bit frz_ok;
    logic [31:0] m_rd;
    logic [31:0] i_rd;
    logic [5:0]  order;

    //                is_mem we  addr      wdata         waits hang exp_rdata     to  lat
    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        0, 1'b0, 32'hE3A01005, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        0, 1'b0, 32'h12345678, 1'b0, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h40,  32'h0,        1, 1'b0, 32'h0BADF00D, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 0, 1'b0, 32'h0BADF00D, 1'b0, 2};
    vecs[4] = '{1'b1, 1'b0, 32'h40,  32'h0,        3, 1'b0, 32'hDEADBEEF, 1'b0, 5};
    vecs[5] = '{1'b0, 1'b0, 32'h40,  32'h0,        2, 1'b0, 32'hDEADBEEF, 1'b0, 4};
    vecs[6] = '{1'b1, 1'b0, 32'h200, 32'h0,        0, 1'b1, 32'h0,        1'b1, WMAX + 1};
    vecs[7] = '{1'b0, 1'b0, 32'h10,  32'h0,        0, 1'b1, 32'h0,        1'b1, WMAX + 1};
    vecs[8] = '{1'b1, 1'b1, 32'h44,  32'hCAFEF00D, 0, 1'b1, 32'h0,        1'b1, WMAX + 1};
    vecs[9] = '{1'b0, 1'b0, 32'h10,  32'h0,        0, 1'b0, 32'hE3A01005, 1'b0, 2};

    smem[32'h10]  = 32'hE3A01005;
    smem[32'h20]  = 32'h11112222;
    smem[32'h40]  = 32'h0BADF00D;
    smem[32'h100] = 32'h12345678;

    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sram_req", 32'(sram_req), 32'd0);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    check("rst_sram_addr", sram_addr, 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_acks", {29'd0, if_ack, mem_ack, timeout}, 32'd0);
    check("rst_freeze", {30'd0, freeze_if, freeze_pipe}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      run_vec(i, vecs[i]);
    end

    // IF and MEM load arrive together: MEM first, IF in the following IDLE.
    @(posedge clk);
    #1;
    sram_waits = 2; never_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h20;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    k = 0; mlat = 0; ilat = 0; frz_ok = 1'b1; m_rd = '0; i_rd = '0;
    while (ilat == 0 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (mem_ack === 1'b1 && mlat == 0) begin
        mlat = k; m_rd = mem_rdata; mem_req = 1'b0;
      end
      if (if_ack === 1'b1) begin
        ilat = k; i_rd = if_rdata; if_req = 1'b0;
      end else if (freeze_if !== 1'b1) begin
        frz_ok = 1'b0;
      end
    end
    mem_req = 1'b0; if_req = 1'b0;
    check("simul_mem_latency", mlat, 4);
    check("simul_if_latency", ilat, 8);
    check("simul_mem_rdata", m_rd, 32'h12345678);
    check("simul_if_rdata", i_rd, 32'h11112222);
    check("simul_freeze_if_until_ack", 32'(frz_ok), 32'd1);

    // Both requesters held: the ack-cycle mask hands each IDLE to the other
    // side, so grants alternate starting with MEM.
    @(posedge clk);
    #1;
    sram_waits = 0;
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    k = 0; nacks = 0; order = '0;
    while (nacks < 6 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (mem_ack === 1'b1 || if_ack === 1'b1) begin
        order[nacks] = mem_ack;
        nacks++;
      end
    end
    mem_req = 1'b0; if_req = 1'b0;
    check("held_ack_count", nacks, 6);
    check("held_grant_order", 32'(order), 32'b010101);
    check("held_cycles", k, 12);

    // Reset in the middle of a MEM grant, then re-grant of the held request.
    @(posedge clk);
    #1;
    never_ack = 1'b1; sram_waits = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    repeat (3) begin @(posedge clk); #1; end
    check("rstmid_sram_req_before", 32'(sram_req), 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid_sram_req_dropped", 32'(sram_req), 32'd0);
    check("rstmid_acks_zero", {30'd0, mem_ack, if_ack}, 32'd0);
    check("rstmid_mem_rdata_zero", mem_rdata, 32'd0);
    @(posedge clk); @(posedge clk);
    #1;
    check("rstmid_held_in_reset", 32'(sram_req), 32'd0);
    never_ack = 1'b0;
    rst = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (mem_ack !== 1'b1 && k < 20);
    m_rd = mem_rdata;
    mem_req = 1'b0;
    check("rstmid_regrant_latency", k, 2);
    check("rstmid_regrant_rdata", m_rd, 32'h12345678);

    // Randomized traffic from both stages against the reference memory.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'h300 + 32'(4 * i);
      d = $urandom;
      smem[a]    = d;
      ref_mem[a] = d;
    end
    exp_mem_rdata = 32'h12345678;
    rand_waits = 1'b1;
    fork
      if_driver(60);
      mem_driver(60);
    join
    rand_waits = 1'b0;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
